mem_arbiter: RTL

- Sequences a single-ported, unified 16-bit memory shared by the instruction-fetch stage and the data-memory stage.
- Arbitrates between the two requesters and holds each access for a configurable number of cycles.
- Returns registered read data with a one-cycle done pulse, rejects misaligned addresses, and issues a one-shot dump when the processor halts.
- Sits between fetch/memory stages and the memory wrapper.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data stages, the arbiter and the memory wrapper.
// The master modport is the arbiter's view; slave is the requesters/memory side.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_err;
  logic        halt;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic        mem_dump;
  logic [15:0] mem_rdata;
  logic        busy;

  modport master (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, halt, mem_rdata,
    output if_rdata, if_done, if_err, dm_rdata, dm_done, dm_err,
           mem_addr, mem_wdata, mem_en, mem_wr, mem_dump, busy
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, halt, mem_rdata,
    input  if_rdata, if_done, if_err, dm_rdata, dm_done, dm_err,
           mem_addr, mem_wdata, mem_en, mem_wr, mem_dump, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sequencing a single-ported unified memory between fetch and data stages,
// with fixed access latency, misalignment rejection and a one-shot dump on halt.
module mem_arbiter #(
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam int unsigned CountW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned StreakW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StHalted} state_e;

  state_e              state_q;
  logic [CountW-1:0]   count_q;
  logic [StreakW-1:0]  streak_q;
  logic [15:0]         addr_q, wdata_q, if_rdata_q, dm_rdata_q;
  logic                wr_q, owner_dm_q;
  logic                if_done_q, if_err_q, dm_done_q, dm_err_q;
  logic                mem_en_q, mem_wr_q, mem_dump_q, busy_q;

  logic        arb_ok, if_elig, dm_elig, grant_dm, grant_any, grant_wr;
  logic [15:0] grant_addr;

  // The requester finishing in RESP still holds req this cycle, so it is masked out.
  always_comb begin
    arb_ok     = ((state_q == StIdle) || (state_q == StResp)) && !bus.halt;
    if_elig    = bus.if_req && !((state_q == StResp) && !owner_dm_q);
    dm_elig    = bus.dm_req && !((state_q == StResp) && owner_dm_q);
    grant_dm   = arb_ok && dm_elig && (!if_elig || (streak_q != StreakW'(MAX_DATA_STREAK)));
    grant_any  = arb_ok && (if_elig || dm_elig);
    grant_addr = grant_dm ? bus.dm_addr : bus.if_addr;
    grant_wr   = grant_dm && bus.dm_wr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      streak_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      owner_dm_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      dm_done_q  <= 1'b0;
      dm_err_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_dump_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      dm_done_q  <= 1'b0;
      dm_err_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_dump_q <= 1'b0;
      unique case (state_q)
        StIdle, StResp: begin
          if (bus.halt) begin
            state_q    <= StHalted;
            mem_dump_q <= 1'b1;
            mem_en_q   <= 1'b0;
            busy_q     <= 1'b0;
          end else if (grant_any) begin
            addr_q     <= grant_addr;
            wdata_q    <= grant_dm ? bus.dm_wdata : '0;
            wr_q       <= grant_wr;
            owner_dm_q <= grant_dm;
            busy_q     <= 1'b1;
            if (!grant_dm) begin
              streak_q <= '0;
            end else if (if_elig && (streak_q != StreakW'(MAX_DATA_STREAK))) begin
              streak_q <= streak_q + 1'b1;
            end
            if (grant_addr[0]) begin
              // Misaligned: skip the memory entirely and answer with an error.
              state_q  <= StResp;
              mem_en_q <= 1'b0;
              if (grant_dm) begin
                dm_done_q  <= 1'b1;
                dm_err_q   <= 1'b1;
                dm_rdata_q <= '0;
              end else begin
                if_done_q  <= 1'b1;
                if_err_q   <= 1'b1;
                if_rdata_q <= '0;
              end
            end else begin
              state_q  <= StAccess;
              count_q  <= CountW'(LATENCY - 1);
              mem_en_q <= 1'b1;
              mem_wr_q <= (LATENCY == 1) && grant_wr;
            end
          end else begin
            state_q  <= StIdle;
            mem_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        StAccess: begin
          if (count_q == '0) begin
            state_q  <= StResp;
            mem_en_q <= 1'b0;
            if (owner_dm_q) begin
              dm_done_q  <= 1'b1;
              dm_rdata_q <= wr_q ? '0 : bus.mem_rdata;
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end else begin
            count_q  <= count_q - 1'b1;
            mem_wr_q <= wr_q && (count_q == CountW'(1));
          end
        end
        default: ;  // StHalted is sticky until reset
      endcase
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_err    = if_err_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_dump  = mem_dump_q;
  assign bus.busy      = busy_q;

endmodule
